// File: rtl/apb_alu_master_arb_pkg.sv
// Shared definitions for the APB ALU master with two-requester arbitration.
// Purpose : FSM state encoding, ALU opcode values and the PWDATA field layout
//           used when packing a command into the APB write word.
// Ports   : none (package).
package apb_alu_master_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_ACCESS,
        RD_SETUP,
        RD_ACCESS,
        RESP
    } alu_state_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam int PW_A_LSB  = 0;
    localparam int PW_A_MSB  = 6;
    localparam int PW_B_LSB  = 7;
    localparam int PW_B_MSB  = 13;
    localparam int PW_OP_LSB = 14;
    localparam int PW_OP_MSB = 15;

    // Builds the APB write word; bits above the opcode field stay zero.
    function automatic logic [31:0] pack_pwdata(input logic [6:0] a,
                                                input logic [6:0] b,
                                                input logic [1:0] op);
        logic [31:0] w;
        w = '0;
        w[PW_A_MSB:PW_A_LSB]   = a;
        w[PW_B_MSB:PW_B_LSB]   = b;
        w[PW_OP_MSB:PW_OP_LSB] = op;
        return w;
    endfunction

endpackage

// File: rtl/apb_alu_master_arb_rr_arb2.sv
// Two-way round-robin arbiter.
// Purpose : picks one of two requesters; when both request, the one that was
//           not granted last wins. After reset requester 0 is favoured.
// Ports   : clk    - clock, rising edge
//           rst    - synchronous active-high reset
//           req    - request vector, bit i = requester i
//           accept - the current grant is being taken; advances the pointer
//           grant  - one-hot grant (zero when no request)
module rr_arb2
    import apb_alu_master_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic prefer_r1;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = prefer_r1 ? 2'b10 : 2'b01;
        end
    end

    // After a grant to requester 0 the next tie goes to requester 1 and vice versa.
    always_ff @(posedge clk) begin
        if (rst) begin
            prefer_r1 <= 1'b0;
        end else if (accept && (grant != 2'b00)) begin
            prefer_r1 <= grant[0];
        end
    end

endmodule

// File: rtl/apb_alu_master_arb.sv
// APB master that forwards ALU commands from two requesters to an APB ALU slave.
// Purpose : arbitrates between two command sources, writes the packed command
//           to the slave, reads back the 16-bit result and returns it to the
//           requester that issued it. A wait counter aborts stuck transfers.
// Ports   : PCLK, PRESET              - clock and synchronous active-high reset
//           req_valid/req_ready [1:0]  - per-requester command handshake
//           req_a/req_b [13:0]         - packed 7-bit signed operands {r1, r0}
//           req_op [3:0]               - packed 2-bit opcodes {r1, r0}
//           rsp_valid [1:0]            - one-hot response pulse
//           rsp_data [15:0], rsp_err   - result and timeout flag
//           PSEL2, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY1 - APB master
module apb_alu_master_arb
    import apb_alu_master_arb_pkg::*;
#(
    parameter logic [31:0] ALU_ADDR = 32'h0000_0010,
    parameter int          TIMEOUT  = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [13:0] req_a,
    input  logic [13:0] req_b,
    input  logic [3:0]  req_op,
    output logic [1:0]  rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        PSEL2,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY1
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    alu_state_e state;
    logic [1:0] owner;
    logic [7:0] wait_cnt;
    logic [1:0] grant;
    logic       accept;
    logic [6:0] sel_a;
    logic [6:0] sel_b;
    logic [1:0] sel_op;
    logic       unused_prdata_hi;

    assign unused_prdata_hi = ^PRDATA[31:16];

    rr_arb2 u_arb (
        .clk    (PCLK),
        .rst    (PRESET),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    // Commands are only taken in IDLE; elsewhere requesters simply keep waiting.
    assign accept    = (state == IDLE) && (grant != 2'b00) && !PRESET;
    assign req_ready = accept ? grant : 2'b00;

    assign sel_a  = grant[1] ? req_a[13:7] : req_a[6:0];
    assign sel_b  = grant[1] ? req_b[13:7] : req_b[6:0];
    assign sel_op = grant[1] ? req_op[3:2] : req_op[1:0];

    // All APB and response outputs are registered and set on the transition
    // into the state that owns them, so they line up with the state register.
    // The write word itself holds the latched command until the write completes.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            owner     <= 2'b00;
            wait_cnt  <= 8'd0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= 32'd0;
            PWDATA    <= 32'd0;
            rsp_valid <= 2'b00;
            rsp_data  <= 16'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 2'b00;
                    rsp_err   <= 1'b0;
                    if (accept) begin
                        owner   <= grant;
                        PSEL2   <= 1'b1;
                        PENABLE <= 1'b0;
                        PWRITE  <= 1'b1;
                        PADDR   <= ALU_ADDR;
                        PWDATA  <= pack_pwdata(sel_a, sel_b, sel_op);
                        state   <= WR_SETUP;
                    end
                end
                WR_SETUP, RD_SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= 8'd0;
                    state    <= (state == WR_SETUP) ? WR_ACCESS : RD_ACCESS;
                end
                WR_ACCESS, RD_ACCESS: begin
                    // PREADY1 wins over a timeout landing in the same cycle.
                    if (PREADY1) begin
                        PENABLE <= 1'b0;
                        if (state == WR_ACCESS) begin
                            PWRITE <= 1'b0;
                            PWDATA <= 32'd0;
                            state  <= RD_SETUP;
                        end else begin
                            PSEL2     <= 1'b0;
                            PADDR     <= 32'd0;
                            rsp_data  <= PRDATA[15:0];
                            rsp_err   <= 1'b0;
                            rsp_valid <= owner;
                            state     <= RESP;
                        end
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        PSEL2     <= 1'b0;
                        PENABLE   <= 1'b0;
                        PWRITE    <= 1'b0;
                        PADDR     <= 32'd0;
                        PWDATA    <= 32'd0;
                        rsp_data  <= 16'd0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= owner;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    rsp_valid <= 2'b00;
                    rsp_err   <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_alu_master_arb.sv
// Testbench for apb_alu_master_arb.
// Purpose : drives ALU commands from both requesters against a behavioural
//           APB ALU slave and compares responses with expected values queued
//           when each command is accepted.
// Ports   : none (top-level bench).
module tb_apb_alu_master_arb;
    import apb_alu_master_arb_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [13:0] req_a;
    logic [13:0] req_b;
    logic [3:0]  req_op;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        PSEL2;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY1;

    apb_alu_master_arb #(
        .ALU_ADDR (32'h0000_0010),
        .TIMEOUT  (16)
    ) u_dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .PSEL2     (PSEL2),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY1   (PREADY1)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [1:0]  who;
        logic [31:0] pw;
        logic [15:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        int          r;
        logic [6:0]  a;
        logic [6:0]  b;
        logic [1:0]  op;
        logic [31:0] pw;
        logic [15:0] data;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[6];

    int n_checks     = 0;
    int n_fail       = 0;
    int cyc          = 0;
    int pen_run      = 0;
    int last_pen_run = 0;
    int last_rsp_cyc = 0;

    // Behavioural ALU slave: PREADY1 on the access_len-th ACCESS cycle unless stalled.
    bit          stall      = 1'b0;
    int          access_len = 2;
    int          acc_cnt    = 0;
    logic [15:0] slave_result = 16'd0;

    function automatic logic [15:0] slave_alu(input logic [15:0] w);
        logic [15:0] opa;
        logic [15:0] opb;
        opa = {{9{w[6]}}, w[6:0]};
        opb = {{9{w[13]}}, w[13:7]};
        case (w[15:14])
            2'b00:   return opa + opb;
            2'b01:   return opa - opb;
            2'b10:   return 16'($signed(opa) * $signed(opb));
            default: return opa ^ opb;
        endcase
    endfunction

    assign PREADY1 = !stall && PSEL2 && PENABLE && (acc_cnt == access_len - 1);
    assign PRDATA  = {16'hA5A5, slave_result};

    always @(posedge PCLK) begin
        cyc <= cyc + 1;
        if (PSEL2 && PENABLE) begin
            if (PREADY1) begin
                acc_cnt <= 0;
                if (PWRITE) slave_result <= slave_alu(PWDATA[15:0]);
            end else begin
                acc_cnt <= acc_cnt + 1;
            end
        end else begin
            acc_cnt <= 0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: bus-phase checks and scoreboard pop on every response pulse.
    always @(negedge PCLK) begin
        if (PENABLE === 1'b1) begin
            pen_run++;
        end else if (pen_run != 0) begin
            last_pen_run = pen_run;
            pen_run      = 0;
        end
        if (PRESET === 1'b0 && PSEL2 && PENABLE && PREADY1) begin
            check_output("paddr", PADDR, 32'h0000_0010);
            if (PWRITE) begin
                if (sb.size() > 0) check_output("pwdata_wr", PWDATA, sb[0].pw);
            end else begin
                check_output("pwdata_rd", PWDATA, 32'd0);
            end
        end
        if (rsp_valid != 2'b00) begin
            last_rsp_cyc = cyc;
            check_output("psel_in_resp", {31'd0, PSEL2}, 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_rsp: got rsp_valid %b, expected none", rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                check_output("rsp_valid", {30'd0, rsp_valid}, {30'd0, mon_e.who});
                check_output("rsp_data", {16'd0, rsp_data}, {16'd0, mon_e.data});
                check_output("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
            end
        end
    end

    task automatic apply_stimulus(input int r, input logic [6:0] a, input logic [6:0] b,
                                  input logic [1:0] op, input logic [31:0] pw,
                                  input logic [15:0] data, input logic err,
                                  output int acc_cyc);
        bit got;
        logic [1:0] who;
        who = (r == 0) ? 2'b01 : 2'b10;
        got = 1'b0;
        acc_cyc = 0;
        @(posedge PCLK); #1;
        if (r == 0) begin
            req_a[6:0] = a; req_b[6:0] = b; req_op[1:0] = op;
        end else begin
            req_a[13:7] = a; req_b[13:7] = b; req_op[3:2] = op;
        end
        req_valid = who;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge PCLK);
            if (req_ready != 2'b00) got = 1'b1;
        end
        if (got) begin
            acc_cyc = cyc;
            check_output("req_ready", {30'd0, req_ready}, {30'd0, who});
            sb.push_back('{who: who, pw: pw, data: data, err: err});
        end else begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: got no req_ready, expected %b", who);
        end
        @(posedge PCLK); #1;
        req_valid = 2'b00;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge PCLK);
            if (sb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: got %0d pending responses, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int k;
        logic [1:0] order[3];
        bit seen;

        vecs[0] = '{r: 0, a: 7'd5,   b: 7'd3,   op: OP_ADD, pw: 32'h0000_0185, data: 16'h0008};
        vecs[1] = '{r: 1, a: 7'h7C,  b: 7'd6,   op: OP_MUL, pw: 32'h0000_837C, data: 16'hFFE8};
        vecs[2] = '{r: 0, a: 7'd10,  b: 7'd20,  op: OP_SUB, pw: 32'h0000_4A0A, data: 16'hFFF6};
        vecs[3] = '{r: 1, a: 7'h55,  b: 7'h2A,  op: OP_XOR, pw: 32'h0000_D555, data: 16'hFFFF};
        vecs[4] = '{r: 0, a: 7'd63,  b: 7'd63,  op: OP_ADD, pw: 32'h0000_1FBF, data: 16'h007E};
        vecs[5] = '{r: 1, a: 7'h40,  b: 7'h40,  op: OP_MUL, pw: 32'h0000_A040, data: 16'h1000};

        // Reset with both requesters asserting: nothing may be accepted.
        PRESET    = 1'b1;
        req_valid = 2'b11;
        req_a     = 14'd0;
        req_b     = 14'd0;
        req_op    = 4'd0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check_output("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check_output("rst_psel", {31'd0, PSEL2}, 32'd0);
        check_output("rst_penable", {31'd0, PENABLE}, 32'd0);
        check_output("rst_pwrite", {31'd0, PWRITE}, 32'd0);
        check_output("rst_paddr", PADDR, 32'd0);
        check_output("rst_pwdata", PWDATA, 32'd0);
        check_output("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check_output("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check_output("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        req_valid = 2'b00;
        PRESET    = 1'b0;

        // Table of single-requester commands, each checked for 8-cycle latency.
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op,
                           vecs[i].pw, vecs[i].data, 1'b0, acc);
            wait_drain($sformatf("drain_vec%0d", i));
            check_output($sformatf("latency_vec%0d", i), last_rsp_cyc - acc + 1, 32'd8);
        end

        // Both requesters held for three commands: grants must alternate r0, r1, r0.
        @(posedge PCLK); #1;
        req_a     = {vecs[1].a, vecs[0].a};
        req_b     = {vecs[1].b, vecs[0].b};
        req_op    = {vecs[1].op, vecs[0].op};
        req_valid = 2'b11;
        k = 0;
        for (int i = 0; i < 100 && k < 3; i++) begin
            @(negedge PCLK);
            if (req_ready != 2'b00) begin
                order[k] = req_ready;
                if (req_ready[1])
                    sb.push_back('{who: 2'b10, pw: vecs[1].pw, data: vecs[1].data, err: 1'b0});
                else
                    sb.push_back('{who: 2'b01, pw: vecs[0].pw, data: vecs[0].data, err: 1'b0});
                k++;
            end
        end
        @(posedge PCLK); #1;
        req_valid = 2'b00;
        check_output("arb_count", k, 32'd3);
        if (k == 3) begin
            check_output("arb_grant0", {30'd0, order[0]}, 32'd1);
            check_output("arb_grant1", {30'd0, order[1]}, 32'd2);
            check_output("arb_grant2", {30'd0, order[2]}, 32'd1);
        end
        wait_drain("drain_arb");

        // Slave never ready: 16 ACCESS cycles, then an error response.
        stall = 1'b1;
        apply_stimulus(0, 7'd1, 7'd2, OP_ADD, 32'h0000_0101, 16'h0000, 1'b1, acc);
        wait_drain("drain_timeout");
        check_output("timeout_penable_cycles", last_pen_run, 32'd16);
        stall = 1'b0;
        apply_stimulus(1, vecs[2].a, vecs[2].b, vecs[2].op, vecs[2].pw, vecs[2].data, 1'b0, acc);
        wait_drain("drain_after_timeout");

        // Reset in the middle of the write access phase drops the command.
        stall = 1'b1;
        apply_stimulus(0, vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].pw, vecs[0].data, 1'b0, acc);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge PCLK);
            if (PSEL2 && PENABLE && PWRITE) seen = 1'b1;
        end
        check_output("reached_wr_access", {31'd0, seen}, 32'd1);
        PRESET = 1'b1;
        sb.delete();
        @(negedge PCLK);
        check_output("midrst_psel", {31'd0, PSEL2}, 32'd0);
        check_output("midrst_penable", {31'd0, PENABLE}, 32'd0);
        check_output("midrst_state", {29'd0, u_dut.state}, {29'd0, IDLE});
        @(negedge PCLK);
        PRESET = 1'b0;
        stall  = 1'b0;
        seen   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            if (rsp_valid != 2'b00) seen = 1'b1;
        end
        check_output("midrst_no_rsp", {31'd0, seen}, 32'd0);
        apply_stimulus(1, vecs[3].a, vecs[3].b, vecs[3].op, vecs[3].pw, vecs[3].data, 1'b0, acc);
        wait_drain("drain_after_reset");

        repeat (3) @(posedge PCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_alu_master_arb.md
APB_ALU_MASTER_ARB -- requirements
Module: apb_alu_master_arb

Interface
REQ-001 SHALL have parameter ALU_ADDR, default 32'h0000_0010, driven on PADDR for every transfer.
REQ-002 SHALL have parameter TIMEOUT, default 16, giving the maximum ACCESS cycles to wait for PREADY1 (range 2..255).
REQ-003 SHALL have port PCLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port PRESET, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 2 bits: per-requester command valid; bit i belongs to requester i.
REQ-006 SHALL have port req_ready, output, 2 bits: per-requester command accepted, a one-cycle pulse.
REQ-007 SHALL have port req_a, input, 14 bits: packed signed operand A, {r1[6:0], r0[6:0]}.
REQ-008 SHALL have port req_b, input, 14 bits: packed signed operand B, same packing as req_a.
REQ-009 SHALL have port req_op, input, 4 bits: packed opcode {r1[1:0], r0[1:0]}, encoded 00 add, 01 sub, 10 mul, 11 xor.
REQ-010 SHALL have port rsp_valid, output, 2 bits: one-hot, one-cycle response pulse to the owning requester.
REQ-011 SHALL have port rsp_data, output, 16 bits: ALU result, valid while rsp_valid is nonzero.
REQ-012 SHALL have port rsp_err, output, 1 bit: timeout flag, qualified by rsp_valid.
REQ-013 SHALL have APB master ports: PSEL2 out 1, PENABLE out 1, PWRITE out 1, PADDR out 32, PWDATA out 32, PRDATA in 32, PREADY1 in 1.

Function
REQ-014 SHALL implement FSM states IDLE, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, RESP.
REQ-015 In IDLE with any req_valid bit set, SHALL grant round-robin:
- priority goes to the requester not granted last; pointer reset value favours requester 0.
- a single requester is granted immediately.
REQ-016 On grant, SHALL:
- pulse req_ready[grant] for one cycle;
- latch that requester's A, B and op;
- go to WR_SETUP.
REQ-017 Requests arriving outside IDLE SHALL wait, with no req_ready and no loss of the pending request.
REQ-018 SETUP states SHALL drive PSEL2=1, PENABLE=0, PADDR=ALU_ADDR, for exactly one cycle.
REQ-019 ACCESS states SHALL drive PSEL2=1 and PENABLE=1, holding all APB outputs stable until PREADY1=1.
REQ-020 Write phase SHALL drive PWRITE=1 and PWDATA = {16'b0, op[1:0], B[6:0], A[6:0]}.
REQ-021 Read phase SHALL drive PWRITE=0 and PWDATA=0.
REQ-022 WR_ACCESS with PREADY1=1 SHALL go to RD_SETUP.
REQ-023 RD_ACCESS with PREADY1=1 SHALL capture PRDATA[15:0] into rsp_data and go to RESP.
REQ-024 A wait counter SHALL clear on entry to each ACCESS state and increment each ACCESS cycle with PREADY1=0.
REQ-025 If the wait counter reaches TIMEOUT-1 with PREADY1=0, the block SHALL:
- abort the transfer, deasserting PSEL2 and PENABLE next cycle;
- set rsp_data=0 and rsp_err=1;
- go to RESP, skipping any remaining phase.
REQ-026 If PREADY1 arrives in the same cycle the timeout would fire, the block SHALL treat the transfer as successful.
REQ-027 RESP SHALL last one cycle with rsp_valid[grant]=1, then return to IDLE.
REQ-028 End-to-end latency with a 2-cycle-ACCESS slave SHALL be 8 cycles, from req_ready pulse to rsp_valid pulse inclusive.
REQ-029 PSEL2 SHALL be 0 in IDLE and RESP, giving at least one idle bus cycle between commands.

Reset
REQ-030 While PRESET=1, the block SHALL:
- hold the FSM in IDLE;
- drive PSEL2, PENABLE, PWRITE, req_ready, rsp_valid and rsp_err to 0;
- drive PADDR, PWDATA and rsp_data to 0;
- set the round-robin pointer to favour requester 0.
REQ-031 Reset asserted mid-transfer SHALL abort with no response pulse; any in-flight command is dropped.

Structure
REQ-032 A shared package SHALL hold:
- the FSM state enum;
- opcode constants;
- the PWDATA field positions A [6:0], B [13:7], op [15:14].
REQ-033 The round-robin arbiter SHALL be one sub-module, rr_arb2: 2-bit request in, one-hot grant out, pointer update on accept.

Verification
REQ-034 Request r0 with A=5, B=3, op=00 against a compliant ALU slave -> APB write PWDATA=32'h0000_0185, then a read; rsp_valid=2'b01, rsp_data=16'h0008, rsp_err=0, 8 cycles after req_ready.
REQ-035 Request r1 with A=-4, B=6, op=10 -> rsp_valid=2'b10, rsp_data=16'hFFE8 (-24).
REQ-036 req_valid=2'b11 held for three commands -> grants in order r0, r1, r0; no two APB transfers overlap.
REQ-037 Slave holding PREADY1=0 -> PENABLE high for exactly 16 cycles, then rsp_err=1 and rsp_data=0; the next command completes normally.
REQ-038 PRESET asserted during WR_ACCESS -> next cycle PSEL2=0, no rsp_valid, FSM in IDLE; a new request is accepted after reset is released.
